// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-state, branch-condition and instruction-field definitions
package cpu_pkg;
    localparam logic [2:0] COND_NEVER = 3'b000;
    localparam logic [2:0] COND_EQ    = 3'b001;
    localparam logic [2:0] COND_NE    = 3'b010;
    localparam logic [2:0] COND_GE    = 3'b011;
    localparam logic [2:0] COND_GT    = 3'b100;
    localparam logic [2:0] COND_LE    = 3'b101;
    localparam logic [2:0] COND_LT    = 3'b110;

    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_EXEC, ST_HALT} fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    function automatic logic [31:0] sext_imm(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction
endpackage

// File: rtl/branch_eval.sv
// branch_eval: decides whether a conditional branch is taken from the rs-rt ALU flags
module branch_eval
    import cpu_pkg::*;
(
    input  logic [2:0] condition,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_ovf,
    output logic       taken
);
    logic lt;
    logic eq;
    assign lt = alu_neg ^ alu_ovf;
    assign eq = alu_zero;
    // signed compare outcome per condition code; unknown codes never branch
    always_comb begin
        taken = 1'b0;
        case (condition)
            COND_EQ: taken = eq;
            COND_NE: taken = !eq;
            COND_GE: taken = !lt;
            COND_GT: taken = !lt && !eq;
            COND_LE: taken = lt || eq;
            COND_LT: taken = lt;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register, instruction fetch handshake and next-PC selection
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc,
    input  logic        exec_done,
    input  logic        jump,
    input  logic [2:0]  condition,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    input  logic        halt_req,
    output logic        halted
);
    fetch_state_t state;
    logic         taken;
    logic [31:0]  pc4;
    logic [31:0]  br_off;
    logic [31:0]  next_pc;

    assign imem_addr = pc;

    branch_eval u_branch_eval (
        .condition(condition),
        .alu_zero (alu_zero),
        .alu_neg  (alu_neg),
        .alu_ovf  (alu_ovf),
        .taken    (taken)
    );

    // next PC: absolute jump beats branch, otherwise sequential; no delay slot
    always_comb begin
        pc4     = pc + 32'd4;
        br_off  = sext_imm(ir[IMM_MSB:IMM_LSB]) << 2;
        next_pc = jump ? {pc4[31:28], ir[TARGET_MSB:TARGET_LSB], 2'b00} : taken ? pc4 + br_off : pc4;
    end

    // fetch sequencer with registered request, instruction and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            ir       <= 32'h0;
            ir_valid <= 1'b0;
            imem_req <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc       <= next_pc;
                        ir_valid <= 1'b0;
                        imem_req <= !halt_req;
                        halted   <= halt_req;
                        state    <= halt_req ? ST_HALT : ST_FETCH;
                    end
                end
                ST_HALT: begin
                    imem_req <= 1'b0;
                end
                default: state <= ST_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized scoreboard bench for the fetch / next-PC unit
module tb_ifetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic        exec_done = 1'b0;
    logic        jump = 1'b0;
    logic [2:0]  condition = 3'b000;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic        alu_ovf = 1'b0;
    logic        halt_req = 1'b0;
    logic        halted;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_fetch_q[$];
    logic [31:0] exp_ir_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] m_pc;

    ifetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .exec_done (exec_done),
        .jump      (jump),
        .condition (condition),
        .alu_zero  (alu_zero),
        .alu_neg   (alu_neg),
        .alu_ovf   (alu_ovf),
        .halt_req  (halt_req),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // reference next-PC: signed comparisons of the operands themselves decide branches
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] i, input logic j,
                                               input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] pc4;
        logic [31:0] off;
        logic        t;
        pc4 = p + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) | ((i & 32'h03FF_FFFF) << 2);
        case (c)
            3'd1: t = (rs == rt);
            3'd2: t = (rs != rt);
            3'd3: t = ($signed(rs) >= $signed(rt));
            3'd4: t = ($signed(rs) >  $signed(rt));
            3'd5: t = ($signed(rs) <= $signed(rt));
            3'd6: t = ($signed(rs) <  $signed(rt));
            default: t = 1'b0;
        endcase
        off = {{16{i[15]}}, i[15:0]};
        return t ? pc4 + (off << 2) : pc4;
    endfunction

    task automatic set_flags(input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] d;
        d = rs - rt;
        alu_zero = (d == 32'h0);
        alu_neg  = d[31];
        alu_ovf  = (rs[31] ^ rt[31]) & (d[31] ^ rs[31]);
    endtask

    task automatic garbage_ctrl();
        jump      = 1'($urandom_range(0, 1));
        condition = 3'($urandom_range(0, 7));
        set_flags($urandom, $urandom);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        exec_done  = 1'b1;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        @(posedge clk); #1;
        chk("rst_ack_discard", ir, 32'h0);
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        exp_fetch_q.delete();
        exp_ir_q.delete();
        exp_pc_q.delete();
        m_pc = RST_PC;
        exp_fetch_q.push_back(RST_PC);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("boot_first_req", {31'h0, imem_req}, 32'h1);
    endtask

    task automatic do_instr(input logic [31:0] instr, input logic j, input logic [2:0] c,
                            input logic [31:0] rs, input logic [31:0] rt, input logic hlt,
                            input int ack_dly, input int done_dly);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (imem_req !== 1'b1) begin
            chk("req_timeout", {31'h0, imem_req}, 32'h1);
            return;
        end
        for (int i = 0; i < ack_dly; i++) begin
            exec_done  = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            garbage_ctrl();
            @(posedge clk); #1;
        end
        exec_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = instr;
        exp_ir_q.push_back(instr);
        exp_pc_q.push_back(m_pc);
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("ir_valid_latency", {31'h0, ir_valid}, 32'h1);
        chk("req_drop_exec", {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < done_dly; i++) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            garbage_ctrl();
            @(posedge clk); #1;
        end
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        jump      = j;
        condition = c;
        set_flags(rs, rt);
        halt_req  = hlt;
        m_pc = model_next(m_pc, instr, j, c, rs, rt);
        if (!hlt) exp_fetch_q.push_back(m_pc);
        @(posedge clk); #1;
        exec_done = 1'b0;
        halt_req  = 1'b0;
        chk("ir_valid_clear", {31'h0, ir_valid}, 32'h0);
        chk("pc_update", pc, m_pc);
        if (hlt) chk("halted_set", {31'h0, halted}, 32'h1);
        else     chk("req_next", {31'h0, imem_req}, 32'h1);
    endtask

    // monitor: checks fetch address on each new request and ir/pc on each fetched instruction
    initial begin
        logic        prev_req;
        logic        prev_iv;
        logic [31:0] held;
        prev_req = 1'b0;
        prev_iv  = 1'b0;
        held     = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_req = 1'b0;
                prev_iv  = 1'b0;
            end else begin
                if (imem_req === 1'b1 && !prev_req) begin
                    if (exp_fetch_q.size() == 0) chk("fetch_unexpected", {31'h0, imem_req}, 32'h0);
                    else begin
                        held = exp_fetch_q.pop_front();
                        chk("fetch_addr", imem_addr, held);
                    end
                end else if (imem_req === 1'b1) begin
                    chk("addr_stable", imem_addr, held);
                end
                if (ir_valid === 1'b1 && !prev_iv) begin
                    if (exp_ir_q.size() == 0) chk("ir_unexpected", {31'h0, ir_valid}, 32'h0);
                    else begin
                        chk("ir_value", ir, exp_ir_q.pop_front());
                        chk("ir_pc", pc, exp_pc_q.pop_front());
                    end
                end
                prev_req = (imem_req === 1'b1);
                prev_iv  = (ir_valid === 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc_hold;
        #1;
        do_reset();
        do_instr(32'h2008_0005, 1'b0, 3'd0, 32'd1, 32'd2, 1'b0, 0, 0);
        chk("tp_seq", pc, 32'h0000_0104);
        do_instr($urandom, 1'b0, 3'd0, 32'd1, 32'd2, 1'b0, 3, 2);
        chk("tp_delayed", pc, 32'h0000_0108);
        do_instr(32'h0800_0080, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 1, 1);
        chk("tp_jump200", pc, 32'h0000_0200);
        do_instr(32'h1000_FFFF, 1'b0, 3'd1, 32'd5, 32'd5, 1'b0, 0, 0);
        chk("tp_beq_taken", pc, 32'h0000_0200);
        do_instr(32'h1000_FFFF, 1'b0, 3'd1, 32'd5, 32'd6, 1'b0, 2, 1);
        chk("tp_beq_not", pc, 32'h0000_0204);
        do_instr(32'h0800_0010, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 0, 0);
        chk("tp_jump40", pc, 32'h0000_0040);
        do_instr(32'h0000_0004, 1'b0, 3'd6, 32'h8000_0000, 32'h0000_0001, 1'b0, 1, 0);
        chk("tp_lt_ovf", pc, 32'h0000_0054);
        do_instr(32'h0800_0000, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 0, 0);
        chk("tp_jump0", pc, 32'h0000_0000);
        do_instr(32'h1000_FFFE, 1'b0, 3'd1, 32'd7, 32'd7, 1'b0, 0, 0);
        chk("tp_back_wrap", pc, 32'hFFFF_FFFC);
        do_instr(32'h0000_0000, 1'b0, 3'd0, 32'd0, 32'd1, 1'b0, 0, 0);
        chk("tp_fall_wrap", pc, 32'h0000_0000);
        do_instr(32'h1000_FFFD, 1'b0, 3'd1, 32'd3, 32'd3, 1'b0, 0, 0);
        chk("tp_to_fff8", pc, 32'hFFFF_FFF8);
        do_instr(32'h0800_0000, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 0, 0);
        chk("tp_jump_f000", pc, 32'hF000_0000);
        do_instr(32'h0800_0010, 1'b1, 3'd1, 32'd9, 32'd9, 1'b0, 0, 0);
        chk("tp_jump_prio", pc, 32'hF000_0040);
        for (int k = 0; k < 40; k++) begin
            rs = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            do_instr($urandom, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), rs, rt, 1'b0,
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end
        begin
            int n;
            n = 0;
            while (imem_req !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("midfetch_req", {31'h0, imem_req}, 32'h1);
            @(posedge clk); #2;
        end
        do_reset();
        do_instr(32'h0000_0002, 1'b0, 3'd2, 32'd1, 32'd2, 1'b0, 1, 1);
        chk("post_rst_branch", pc, 32'h0000_010C);
        do_instr($urandom, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 0, 1);
        pc_hold = m_pc;
        for (int k = 0; k < 6; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            exec_done  = 1'b1;
            garbage_ctrl();
            @(posedge clk); #1;
            chk("halt_no_req", {31'h0, imem_req}, 32'h0);
            chk("halt_stays", {31'h0, halted}, 32'h1);
            chk("halt_pc", pc, pc_hold);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        chk("fetch_q_empty", exp_fetch_q.size(), 32'h0);
        chk("ir_q_empty", exp_ir_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
